pilots_remove: RTL and testbench

PILOTS_REMOVE -- requirements
Module: pilots_remove

---
 rtl/pilots_remove_if.sv | 33 +++
 rtl/pilots_remove.sv | 106 ++++++++++
 tb/tb_pilots_remove.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pilots_remove_if.sv
// Sink/source strobe bundle between FFT, pilots_remove and QPSK demod.
// PILOT_ERR_CNT_EN adds the pilot error count output.
interface pilots_remove_if;
  logic [31:0] DAT_I;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic        ACK_O;
  logic [31:0] DAT_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I;
`ifdef PILOT_ERR_CNT_EN
  logic [15:0] PILOT_ERR_O;
`endif

  modport master (
    output DAT_I, CYC_I, STB_I, WE_I, ACK_I,
    input  ACK_O, DAT_O, CYC_O, STB_O, WE_O
`ifdef PILOT_ERR_CNT_EN
    , input PILOT_ERR_O
`endif
  );

  modport slave (
    input  DAT_I, CYC_I, STB_I, WE_I, ACK_I,
    output ACK_O, DAT_O, CYC_O, STB_O, WE_O
`ifdef PILOT_ERR_CNT_EN
    , output PILOT_ERR_O
`endif
  );
endinterface

// File: rtl/pilots_remove.sv
// Drops null and pilot bins from an FFT symbol, forwards data bins.
// Define PILOT_ERR_CNT_EN to add the pilot sign-error counter.
module pilots_remove #(
  parameter int NFFT          = 2048,
  parameter int NUSED_HALF    = 840,
  parameter int PILOT_SPACING = 7,
  parameter int PILOT_OFFSET  = 0
) (
  input logic CLK_I,
  input logic RST_I,
  pilots_remove_if.slave bus
);

  localparam int KW = $clog2(NFFT);
  localparam int PW =
    (PILOT_SPACING > 1) ? $clog2(PILOT_SPACING) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(NFFT - 1);
  localparam logic [31:0]   NU_LO  = 32'(NUSED_HALF);
  localparam logic [31:0]   NU_HI  = 32'(NFFT - NUSED_HALF);
  localparam logic [PW-1:0] PH_LAST = PW'(PILOT_SPACING - 1);
  // phase is (k - offset) mod spacing, so a pilot sits at phase 0
  localparam logic [PW-1:0] PH_START = PW'(
    (PILOT_SPACING - (PILOT_OFFSET % PILOT_SPACING))
    % PILOT_SPACING);

  logic [KW-1:0] bin_q, bin_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [31:0]   dat_q, dat_d;
  logic          full_q, full_d;

  logic [31:0] k32;
  logic is_null, is_pilot, is_data;
  logic ack, acc, take, give;

  assign k32      = 32'(bin_q);
  assign is_null  = (bin_q == '0)
                  || (k32 > NU_LO && k32 < NU_HI);
  assign is_pilot = !is_null && (ph_q == '0);
  assign is_data  = !is_null && !is_pilot;

  // dropped bins never wait on the output register
  assign ack  = bus.STB_I & bus.CYC_I
              & (!is_data | !full_q | bus.ACK_I);
  assign acc  = bus.CYC_I & bus.STB_I & bus.WE_I & ack;
  assign take = acc & is_data;
  assign give = full_q & bus.ACK_I;

  always_comb begin
    bin_d  = bin_q;
    ph_d   = ph_q;
    full_d = take | (full_q & !give);
    dat_d  = take ? bus.DAT_I : dat_q;
    if (!bus.CYC_I) begin
      bin_d = '0;
      ph_d  = PH_START;
    end else if (acc) begin
      if (bin_q == K_LAST) begin
        bin_d = '0;
        ph_d  = PH_START;
      end else begin
        bin_d = bin_q + KW'(1);
        ph_d  = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      bin_q  <= '0;
      ph_q   <= PH_START;
      dat_q  <= '0;
      full_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      ph_q   <= ph_d;
      dat_q  <= dat_d;
      full_q <= full_d;
    end
  end

  assign bus.ACK_O = ack;
  assign bus.DAT_O = dat_q;
  assign bus.STB_O = full_q;
  assign bus.WE_O  = full_q;
  assign bus.CYC_O = bus.CYC_I | full_q;

`ifdef PILOT_ERR_CNT_EN
  logic [15:0] perr_q;

  // pilots are BPSK +1, so a set I sign bit is an error
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      perr_q <= '0;
    end else if (acc) begin
      if (bin_q == '0)
        perr_q <= '0;
      else if (is_pilot && bus.DAT_I[31] && perr_q != '1)
        perr_q <= perr_q + 16'd1;
    end
  end

  assign bus.PILOT_ERR_O = perr_q;
`endif

endmodule

// File: tb/tb_pilots_remove.sv
// Randomized bench for pilots_remove with a bin-classifying
// reference model; small geometry NFFT=16.
module tb_pilots_remove;

  localparam int NFFT = 16;
  localparam int NU   = 6;
  localparam int PS   = 4;
  localparam int PO   = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pilots_remove_if bus();

  pilots_remove #(
    .NFFT(NFFT),
    .NUSED_HALF(NU),
    .PILOT_SPACING(PS),
    .PILOT_OFFSET(PO)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .bus(bus)
  );

  int vectors;
  int miscompares;
  int ack_bad;
  int mk;
  bit held;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] ref_seq[8];

  function automatic bit is_data(int k);
    bit nul;
    nul = (k == 0) || (k > NU && k < NFFT - NU);
    return !nul && ((k % PS) != PO);
  endfunction

  // reference: bin index from accepted-word count, 1-deep holding
  always @(negedge clk) begin
    bit eack;
    if (rst) begin
      mk = 0;
      held = 0;
      exp_q.delete();
      got_q.delete();
      acc_q.delete();
    end else begin
      eack = bus.STB_I & bus.CYC_I
           & (!is_data(mk) | !held | bus.ACK_I);
      if (bus.ACK_O !== eack) ack_bad++;
      if (bus.STB_O === 1'b1 && bus.ACK_I) begin
        got_q.push_back(bus.DAT_O);
        held = 0;
      end
      if (bus.CYC_I & bus.STB_I & bus.WE_I & bus.ACK_O) begin
        acc_q.push_back(bus.DAT_I);
        if (is_data(mk)) begin
          exp_q.push_back(bus.DAT_I);
          held = 1;
        end
        mk = (mk + 1) % NFFT;
      end else if (!bus.CYC_I) begin
        mk = 0;
      end
    end
  end

  function automatic logic [31:0] word(int mode, int k);
    logic [31:0] w;
    case (mode)
      0: w = 32'(k);
      1: w = $urandom;
      default: begin
        w = (k == 2 || k == 3 || k == 10)
          ? 32'hFFFF_0000 : 32'h0001_0000;
        w[15:0] = 16'(k);
      end
    endcase
    return w;
  endfunction

  task automatic run_words(input int n, input int ackm,
                           input int datm, input int base);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 400) begin
      @(posedge clk); #1;
      bus.CYC_I = 1'b1;
      bus.STB_I = 1'b1;
      bus.WE_I  = 1'b1;
      bus.DAT_I = word(datm, base + i);
      case (ackm)
        0: bus.ACK_I = 1'b1;
        1: bus.ACK_I = ($urandom_range(0, 3) != 0);
        default: bus.ACK_I = 1'b0;
      endcase
      @(negedge clk);
      if (bus.ACK_O) i++;
      guard++;
    end
    vectors++;
    if (i != n) begin
      miscompares++;
      $display("FAIL run_words accepted=%0d want=%0d", i, n);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    bus.ACK_I = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic flush();
    idle(3);
    #1;
    got_q.delete();
    exp_q.delete();
    acc_q.delete();
    ack_bad = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    bus.ACK_I = 1'b0;
    bus.DAT_I = '0;
    #3;
    vectors++;
    if (bus.STB_O !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stb got=%b want=0", bus.STB_O);
    end
    vectors++;
    if (bus.WE_O !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_we got=%b want=0", bus.WE_O);
    end
    vectors++;
    if (bus.DAT_O !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_dat got=%h want=0", bus.DAT_O);
    end
    vectors++;
    if (bus.CYC_O !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_cyc got=%b want=0", bus.CYC_O);
    end
    vectors++;
    if (bus.ACK_O !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ack got=%b want=0", bus.ACK_O);
    end
    @(negedge clk); #2;
    rst = 1'b0;
    flush();
  endtask

  task automatic test_stream();
    flush();
    for (int k = 0; k < NFFT; k++) begin
      @(posedge clk); #1;
      bus.CYC_I = 1'b1;
      bus.STB_I = 1'b1;
      bus.WE_I  = 1'b1;
      bus.DAT_I = 32'(k);
      bus.ACK_I = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.ACK_O !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_ack bin=%0d got=%b want=1",
                 k, bus.ACK_O);
      end
    end
    idle(3);
    vectors++;
    if (got_q.size() != 8) begin
      miscompares++;
      $display("FAIL stream_cnt got=%0d want=8", got_q.size());
    end
    for (int j = 0; j < 8 && j < got_q.size(); j++) begin
      vectors++;
      if (got_q[j] !== ref_seq[j]) begin
        miscompares++;
        $display("FAIL stream_dat[%0d] got=%0d want=%0d",
                 j, got_q[j], ref_seq[j]);
      end
    end
    vectors++;
    if (ack_bad != 0) begin
      miscompares++;
      $display("FAIL stream_ackmodel got=%0d want=0", ack_bad);
    end
  endtask

  task automatic test_stall();
    int k;
    int stall;
    int guard;
    flush();
    k = 0;
    stall = 0;
    guard = 0;
    while (k < NFFT && guard < 100) begin
      @(posedge clk); #1;
      bus.CYC_I = 1'b1;
      bus.STB_I = 1'b1;
      bus.WE_I  = 1'b1;
      bus.DAT_I = 32'(k);
      if (bus.STB_O && bus.DAT_O == 32'd3 && stall < 5)
        bus.ACK_I = 1'b0;
      else
        bus.ACK_I = 1'b1;
      @(negedge clk);
      if (!bus.ACK_I) begin
        stall++;
        vectors++;
        if (bus.DAT_O !== 32'd3 || bus.STB_O !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_hold got=%0d/%b want=3/1",
                   bus.DAT_O, bus.STB_O);
        end
        vectors++;
        if (bus.ACK_O !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_ack got=%b want=0", bus.ACK_O);
        end
      end
      if (bus.ACK_O) k++;
      guard++;
    end
    idle(3);
    vectors++;
    if (stall != 5) begin
      miscompares++;
      $display("FAIL stall_cycles got=%0d want=5", stall);
    end
    vectors++;
    if (got_q.size() != 8) begin
      miscompares++;
      $display("FAIL stall_cnt got=%0d want=8", got_q.size());
    end
    for (int j = 0; j < 8 && j < got_q.size(); j++) begin
      vectors++;
      if (got_q[j] !== ref_seq[j]) begin
        miscompares++;
        $display("FAIL stall_dat[%0d] got=%0d want=%0d",
                 j, got_q[j], ref_seq[j]);
      end
    end
    vectors++;
    if (ack_bad != 0) begin
      miscompares++;
      $display("FAIL stall_ackmodel got=%0d want=0", ack_bad);
    end
  endtask

  task automatic test_back_to_back();
    flush();
    run_words(3 * NFFT, 1, 1, 0);
    idle(4);
    vectors++;
    if (got_q.size() != 24 || exp_q.size() != 24) begin
      miscompares++;
      $display("FAIL b2b_cnt got=%0d want=24 model=%0d",
               got_q.size(), exp_q.size());
    end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      vectors++;
      if (got_q[j] !== exp_q[j]) begin
        miscompares++;
        $display("FAIL b2b_dat[%0d] got=%h want=%h",
                 j, got_q[j], exp_q[j]);
      end
    end
    vectors++;
    if (got_q.size() > 8 && acc_q.size() > 17
        && got_q[8] !== acc_q[17]) begin
      miscompares++;
      $display("FAIL b2b_sym2 got=%h want=%h",
               got_q[8], acc_q[17]);
    end
    vectors++;
    if (ack_bad != 0) begin
      miscompares++;
      $display("FAIL b2b_ackmodel got=%0d want=0", ack_bad);
    end
  endtask

  task automatic test_cyc_drop();
    flush();
    run_words(6, 0, 0, 0);
    run_words(2, 2, 0, 6);
    @(posedge clk); #1;
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.ACK_I = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.STB_O !== 1'b1 || bus.DAT_O !== 32'd5) begin
      miscompares++;
      $display("FAIL drop_hold got=%0d/%b want=5/1",
               bus.DAT_O, bus.STB_O);
    end
    vectors++;
    if (bus.CYC_O !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_cyco got=%b want=1", bus.CYC_O);
    end
    @(posedge clk); #1;
    bus.ACK_I = 1'b1;
    @(negedge clk);
    run_words(NFFT, 0, 0, 0);
    idle(3);
    vectors++;
    if (got_q.size() != 12) begin
      miscompares++;
      $display("FAIL drop_cnt got=%0d want=12", got_q.size());
    end
    vectors++;
    if (got_q.size() > 4
        && (got_q[3] !== 32'd5 || got_q[4] !== 32'd1)) begin
      miscompares++;
      $display("FAIL drop_seam got=%0d,%0d want=5,1",
               got_q[3], got_q[4]);
    end
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      vectors++;
      if (got_q[j] !== exp_q[j]) begin
        miscompares++;
        $display("FAIL drop_dat[%0d] got=%0d want=%0d",
                 j, got_q[j], exp_q[j]);
      end
    end
    vectors++;
    if (ack_bad != 0) begin
      miscompares++;
      $display("FAIL drop_ackmodel got=%0d want=0", ack_bad);
    end
  endtask

  task automatic test_async_reset();
    flush();
    run_words(5, 0, 0, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    #1;
    vectors++;
    if (bus.STB_O !== 1'b0 || bus.WE_O !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_stb got=%b/%b want=0/0",
               bus.STB_O, bus.WE_O);
    end
    vectors++;
    if (bus.DAT_O !== 32'h0 || bus.CYC_O !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_dat got=%h/%b want=0/0",
               bus.DAT_O, bus.CYC_O);
    end
    @(negedge clk); #2;
    rst = 1'b0;
    run_words(NFFT, 0, 0, 0);
    idle(3);
    vectors++;
    if (got_q.size() != 8) begin
      miscompares++;
      $display("FAIL arst_cnt got=%0d want=8", got_q.size());
    end
    for (int j = 0; j < 8 && j < got_q.size(); j++) begin
      vectors++;
      if (got_q[j] !== ref_seq[j]) begin
        miscompares++;
        $display("FAIL arst_dat[%0d] got=%0d want=%0d",
                 j, got_q[j], ref_seq[j]);
      end
    end
    vectors++;
    if (ack_bad != 0) begin
      miscompares++;
      $display("FAIL arst_ackmodel got=%0d want=0", ack_bad);
    end
  endtask

`ifdef PILOT_ERR_CNT_EN
  task automatic test_pilot_err();
    flush();
    run_words(NFFT, 0, 2, 0);
    @(posedge clk); #1;
    bus.STB_I = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.PILOT_ERR_O !== 16'd2) begin
      miscompares++;
      $display("FAIL perr_cnt got=%0d want=2", bus.PILOT_ERR_O);
    end
    run_words(1, 0, 2, 0);
    @(posedge clk); #1;
    bus.STB_I = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.PILOT_ERR_O !== 16'd0) begin
      miscompares++;
      $display("FAIL perr_clr got=%0d want=0", bus.PILOT_ERR_O);
    end
    idle(3);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    ack_bad = 0;
    mk = 0;
    held = 0;
    ref_seq = '{32'd1, 32'd3, 32'd4, 32'd5,
                32'd11, 32'd12, 32'd13, 32'd15};
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_cyc_drop();
    test_async_reset();
`ifdef PILOT_ERR_CNT_EN
    test_pilot_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
